// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and
// the helper that sizes the step counter.
package shift_add_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int DEF_WIDTH = 4;

   // Keeps the counter at least one bit wide for degenerate WIDTH=1 builds.
   function automatic int count_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int CW = count_width(DEF_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// WIDTH-bit ripple-carry adder: a chain of full-adder cells, carry-to-carry.
module ripple_adder_w #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   logic [WIDTH:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic p;
      assign p        = a[i] ^ b[i];
      assign s[i]     = p ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
   end

   assign co = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned multiplier: one add-and-shift step per cycle through a
// single WIDTH-bit ripple adder, with a start/ready/done handshake.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = count_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e              state_q,   state_d;
   logic [WIDTH-1:0]    mcand_q,   mcand_d;
   logic [WIDTH-1:0]    acc_hi_q,  acc_hi_d;
   logic [WIDTH-1:0]    acc_lo_q,  acc_lo_d;
   logic                carry_q,   carry_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [2*WIDTH-1:0]  product_q, product_d;

   logic [WIDTH-1:0]    addend;
   logic [WIDTH-1:0]    sum;
   logic                sum_co;

   assign addend = acc_lo_q[0] ? mcand_q : '0;

   // carry_q is cleared on load and by every shift, so the adder always sees ci=0.
   ripple_adder_w #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a  (acc_hi_q),
      .b  (addend),
      .ci (carry_q),
      .s  (sum),
      .co (sum_co)
   );

   // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      carry_d   = carry_q;
      count_d   = count_q;
      product_d = product_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CALC;
               mcand_d  = a;
               acc_hi_d = '0;
               acc_lo_d = b;
               carry_d  = 1'b0;
               count_d  = '0;
            end
         end
         CALC: begin
            // {carry, acc_hi, acc_lo} <= {0, co, sum, acc_lo} >> 1
            carry_d  = 1'b0;
            acc_hi_d = {sum_co, sum[WIDTH-1:1]};
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            count_d  = count_q + 1'b1;
            if (count_q == LAST_CNT) begin
               state_d   = DONE;
               product_d = {acc_hi_d, acc_lo_d};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         carry_q   <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         carry_q   <= carry_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign ready   = (state_q == IDLE);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule
